pfc_qenc: RTL and testbench
===========================

# pfc_qenc

Two-channel quadrature encoder peripheral sitting directly on the PFC side of the `pfcif` port of `olive_std_core`: it consumes the 37-bit `pfcif_cmd` bus and drives the 32-bit `pfcif_resp` bus back into the Nios II system.

- Each channel has a 32-bit signed position counter, a transition-error flag and an index-pulse capture register.
- All eight registers are accessed through PFC commands.

## Interface
- `CNT_W`, default 32: counter/latch width; fixed at 32 to match `pfc_resp`.
- `ID_VALUE`, default 32'h5145_4E43: constant returned at address 6 ("QENC").
- `pfc_clk` input 1: sole clock, driven from `pfcif_pfc_clk`.
- `pfc_reset` input 1: asynchronous, active-high reset, from `pfcif_pfc_reset`.
- `pfc_cmd` input 37: command bus.
  - [36] strobe, one-cycle pulse.
  - [35] write=1 / read=0.
  - [34:32] register address.
  - [31:0] write data.
- `pfc_resp` output 32: registered read data.
- `qa` input 2: encoder A phase per channel, asynchronous.
- `qb` input 2: encoder B phase per channel, asynchronous.
- `qz` input 2: encoder index per channel, asynchronous.

## Operation
- Register map (address: name):
  - 0 CTRL (RW): bit0/1 enable ch0/ch1; bit4/5 invert direction ch0/ch1. Other bits read 0.
  - 1 STATUS: bit0/1 error ch0/ch1, sticky, write-1-to-clear. Bits 9:8 are synced {B,A} of ch0 and bits 11:10 of ch1, read-only.
  - 2/3 COUNT0/COUNT1 (RW): a write loads the counter.
  - 4/5 LATCH0/LATCH1 (RO): count captured at the index rising edge.
  - 6 ID (RO): returns `ID_VALUE`.
  - 7 reads 0; writes are ignored.
- Per channel, inputs pass a 2-FF synchronizer, then a `prev` register.
- Decode compares `cur={A,B}` against `prev`, Gray order 00→01→11→10→00:
  - Forward step: +1. Reverse step: −1. Both are negated when invert=1.
  - Both bits changed: no count change, error flag set.
  - No change: nothing happens.
- Counter wraps modulo 2^32: 32'hFFFF_FFFF+1 → 0, and 0−1 → 32'hFFFF_FFFF.
- Disabled channel: `prev` keeps tracking the synced inputs; there is no count, no error and no capture. Because of this, enabling never produces a spurious step.
- Index: rising edge on the synced Z (enabled channel) loads LATCH with the counter register value as it stood before this cycle's update.
- Simultaneous events:
  - COUNT write and decoded step in the same cycle: the write wins and the step is lost.
  - Error set and W1C in the same cycle: set wins.
  - Write to an RO address: ignored.
  - Strobe with no valid command while reset is asserted: ignored.
- Reset values: `pfc_resp`=0; CTRL, STATUS flags, COUNT, LATCH, sync and `prev` registers all 0.
- Reset mid-operation: all state clears immediately. The next command after release is handled normally.

## Timing
- Read latency 1: `pfc_resp` is valid on the edge after the strobe and is held until the next read strobe. Writes leave `pfc_resp` unchanged.
- Write takes effect at the strobe edge and is visible to a read strobed on the next cycle.
- Pin to counter: an input change sampled at edge N reaches sync stage 2 at N+1. COUNT updates at edge N+2.
- Minimum legal quadrature edge spacing: 3 `pfc_clk` cycles. Anything closer can raise an error.
- Back-to-back strobes on every cycle are supported. There is no busy state.

## Structure
- Package `pfc_qenc_pkg`: holds the `CMD_STB`/`CMD_WR`/`CMD_ADDR` bit positions, the address constants `A_CTRL`…`A_ID`, `ID_VALUE`, and `qstep_t` (enum NONE/INC/DEC/ERR).
- Sub-module `qenc_channel`, instantiated ×2. It contains:
  - synchronizers, `prev` register and decode;
  - counter with load port;
  - index edge detect and latch;
  - error-set pulse output.
- The top level holds the command decoder, CTRL/STATUS registers and the read mux.

## Test plan
- Reset then read address 6 → `pfc_resp`=32'h5145_4E43 one cycle after strobe. Reads of 0–5 all return 0.
- Enable ch0, drive 4 forward Gray steps spaced 4 cycles → COUNT0=4. Set invert and drive 4 more forward steps → COUNT0=0.
- Write COUNT1=32'hFFFF_FFFF, enable ch1, drive 1 forward step → COUNT1=0. Drive 1 reverse step → 32'hFFFF_FFFF.
- Ch0 AB 00→11 in one change → STATUS bit0=1 and COUNT unchanged. Write STATUS=1 in the same cycle as a new error → bit0 remains 1. Clear with no new error → 0.
- COUNT0=10, raise qz[0] coincident with a forward step → LATCH0=10 and COUNT0=11. Disabled channel with qz toggling → LATCH stays 0.
- Assert `pfc_reset` mid-count → all registers and `pfc_resp` are 0. After release, enable ch0 with AB static at 11 → COUNT0 stays 0.

Source files
------------

// File: rtl/pfc_qenc_pkg.sv
// pfc_qenc shared definitions: command bus layout, register map,
// identity constant and the quadrature step decoder.
package pfc_qenc_pkg;

  localparam int CMD_W       = 37;
  localparam int CMD_STB     = 36;
  localparam int CMD_WR      = 35;
  localparam int CMD_ADDR_HI = 34;
  localparam int CMD_ADDR_LO = 32;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_COUNT0 = 3'd2;
  localparam logic [2:0] A_COUNT1 = 3'd3;
  localparam logic [2:0] A_LATCH0 = 3'd4;
  localparam logic [2:0] A_LATCH1 = 3'd5;
  localparam logic [2:0] A_ID     = 3'd6;

  localparam logic [31:0] ID_VALUE = 32'h5145_4E43;

  typedef enum logic [1:0] {
    NONE,
    INC,
    DEC,
    ERR
  } qstep_t;

  // Gray order 00 -> 01 -> 11 -> 10 -> 00 is forward, on {A,B}.
  function automatic qstep_t qdecode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    qstep_t s;
    s = NONE;
    unique case ({prev, cur})
      4'b00_01, 4'b01_11,
      4'b11_10, 4'b10_00: s = INC;
      4'b01_00, 4'b11_01,
      4'b10_11, 4'b00_10: s = DEC;
      4'b00_11, 4'b11_00,
      4'b01_10, 4'b10_01: s = ERR;
      default:            s = NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pfc_qenc_channel.sv
// One quadrature channel: sync, decode, position counter, index latch.
// Ports: clk/rst, en/inv, raw a/b/z, load, count/latch/err/{B,A} out.
module qenc_channel
  import pfc_qenc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         inv_i,
  input  logic         a_i,
  input  logic         b_i,
  input  logic         z_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] latch_o,
  output logic         err_o,
  output logic [1:0]   ab_o
);

  // Pipelines hold {z, a, b}.
  logic [2:0]   s1_q;
  logic [2:0]   s2_q;
  logic [2:0]   prev_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] lat_q;
  logic [W-1:0] lat_d;
  qstep_t       step;
  logic         zrise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      lat_q  <= '0;
    end else begin
      s1_q   <= {z_i, a_i, b_i};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
      lat_q  <= lat_d;
    end
  end

  // prev tracks even when disabled, so enabling never
  // sees a stale phase and cannot produce a false step.
  always_comb begin
    step  = NONE;
    zrise = 1'b0;
    cnt_d = cnt_q;
    lat_d = lat_q;
    if (en_i) begin
      step  = qdecode(prev_q[1:0], s2_q[1:0]);
      zrise = s2_q[2] & ~prev_q[2];
    end
    if (zrise) begin
      lat_d = cnt_q;
    end
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else begin
      unique case (step)
        INC: cnt_d = inv_i ? cnt_q - W'(1)
                           : cnt_q + W'(1);
        DEC: cnt_d = inv_i ? cnt_q + W'(1)
                           : cnt_q - W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign latch_o = lat_q;
  assign err_o   = (step == ERR);
  assign ab_o    = {s2_q[0], s2_q[1]};

endmodule

// File: rtl/pfc_qenc.sv
// Two-channel quadrature encoder on the PFC command/response bus.
// Ports: pfc_clk/reset, 37b cmd in, 32b resp out, qa/qb/qz pins.
module pfc_qenc #(
  parameter int          CNT_W    = 32,
  parameter logic [31:0] ID_VALUE = 32'h5145_4E43
) (
  input  logic        pfc_clk,
  input  logic        pfc_reset,
  input  logic [36:0] pfc_cmd,
  output logic [31:0] pfc_resp,
  input  logic [1:0]  qa,
  input  logic [1:0]  qb,
  input  logic [1:0]  qz
);
  import pfc_qenc_pkg::*;

  logic        stb;
  logic        we;
  logic        re;
  logic [2:0]  addr;
  logic [31:0] wdata;

  logic [1:0]  en_q;
  logic [1:0]  en_d;
  logic [1:0]  inv_q;
  logic [1:0]  inv_d;
  logic [1:0]  err_q;
  logic [1:0]  err_d;
  logic [31:0] resp_q;
  logic [31:0] resp_d;

  logic [1:0]       ld;
  logic [1:0]       err_p;
  logic [CNT_W-1:0] cnt   [2];
  logic [CNT_W-1:0] lat   [2];
  logic [1:0]       ab    [2];

  assign stb   = pfc_cmd[CMD_STB];
  assign we    = stb & pfc_cmd[CMD_WR];
  assign re    = stb & ~pfc_cmd[CMD_WR];
  assign addr  = pfc_cmd[CMD_ADDR_HI:CMD_ADDR_LO];
  assign wdata = pfc_cmd[31:0];

  assign ld[0] = we && (addr == A_COUNT0);
  assign ld[1] = we && (addr == A_COUNT1);

  for (genvar c = 0; c < 2; c++) begin : g_ch
    qenc_channel #(
      .W(CNT_W)
    ) u_ch (
      .clk_i    (pfc_clk),
      .rst_i    (pfc_reset),
      .en_i     (en_q[c]),
      .inv_i    (inv_q[c]),
      .a_i      (qa[c]),
      .b_i      (qb[c]),
      .z_i      (qz[c]),
      .ld_i     (ld[c]),
      .ld_val_i (wdata[CNT_W-1:0]),
      .cnt_o    (cnt[c]),
      .latch_o  (lat[c]),
      .err_o    (err_p[c]),
      .ab_o     (ab[c])
    );
  end

  always_ff @(posedge pfc_clk or posedge pfc_reset) begin
    if (pfc_reset) begin
      en_q   <= '0;
      inv_q  <= '0;
      err_q  <= '0;
      resp_q <= '0;
    end else begin
      en_q   <= en_d;
      inv_q  <= inv_d;
      err_q  <= err_d;
      resp_q <= resp_d;
    end
  end

  always_comb begin
    en_d  = en_q;
    inv_d = inv_q;
    err_d = err_q;
    if (we && (addr == A_CTRL)) begin
      en_d  = wdata[1:0];
      inv_d = wdata[5:4];
    end
    if (we && (addr == A_STATUS)) begin
      err_d = err_q & ~wdata[1:0];
    end
    // A new error outranks a same-cycle clear.
    err_d = err_d | err_p;
  end

  always_comb begin
    resp_d = resp_q;
    if (re) begin
      unique case (addr)
        A_CTRL:   resp_d = {26'd0, inv_q,
                            2'd0, en_q};
        A_STATUS: resp_d = {20'd0, ab[1], ab[0],
                            6'd0, err_q};
        A_COUNT0: resp_d = 32'(cnt[0]);
        A_COUNT1: resp_d = 32'(cnt[1]);
        A_LATCH0: resp_d = 32'(lat[0]);
        A_LATCH1: resp_d = 32'(lat[1]);
        A_ID:     resp_d = ID_VALUE;
        default:  resp_d = '0;
      endcase
    end
  end

  assign pfc_resp = resp_q;

endmodule

// File: tb/tb_pfc_qenc.sv
// Bench for pfc_qenc: directed literal checks plus random traffic
// compared every cycle against a behavioural model.
module tb_pfc_qenc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [36:0] cmd = '0;
  logic [31:0] resp;
  logic [1:0]  qa = '0;
  logic [1:0]  qb = '0;
  logic [1:0]  qz = '0;

  int errs   = 0;
  int checks = 0;
  int pos [2];

  pfc_qenc dut (
    .pfc_clk   (clk),
    .pfc_reset (rst),
    .pfc_cmd   (cmd),
    .pfc_resp  (resp),
    .qa        (qa),
    .qb        (qb),
    .qz        (qz)
  );

  always #5 clk = ~clk;

  // Model: input history, counters, latches, flags.
  logic [1:0]  ha [3];
  logic [1:0]  hb [3];
  logic [1:0]  hz [3];
  logic [31:0] m_cnt [2];
  logic [31:0] m_lat [2];
  logic [1:0]  m_en;
  logic [1:0]  m_inv;
  logic [1:0]  m_err;
  logic [31:0] m_resp;

  // Gray {a,b} to position 0..3.
  function automatic int gpos(logic a, logic b);
    return int'({a, a ^ b});
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    logic        we;
    logic        re;
    logic [2:0]  ad;
    logic [31:0] wd;
    logic [31:0] rv;
    int          d;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        ha[k] <= '0;
        hb[k] <= '0;
        hz[k] <= '0;
      end
      for (int c = 0; c < 2; c++) begin
        m_cnt[c] <= '0;
        m_lat[c] <= '0;
      end
      m_en   <= '0;
      m_inv  <= '0;
      m_err  <= '0;
      m_resp <= '0;
    end else begin
      we = cmd[36] & cmd[35];
      re = cmd[36] & ~cmd[35];
      ad = cmd[34:32];
      wd = cmd[31:0];
      ha[0] <= qa; ha[1] <= ha[0]; ha[2] <= ha[1];
      hb[0] <= qb; hb[1] <= hb[0]; hb[2] <= hb[1];
      hz[0] <= qz; hz[1] <= hz[0]; hz[2] <= hz[1];
      for (int c = 0; c < 2; c++) begin
        d = (gpos(ha[1][c], hb[1][c])
           - gpos(ha[2][c], hb[2][c])) & 3;
        if (m_en[c] && d == 2)
          m_err[c] <= 1'b1;
        else if (we && ad == 3'd1 && wd[c])
          m_err[c] <= 1'b0;
        if (m_en[c] && hz[1][c] && !hz[2][c])
          m_lat[c] <= m_cnt[c];
        if (we && ad == 3'(2 + c))
          m_cnt[c] <= wd;
        else if (m_en[c] && (d == 1 || d == 3))
          m_cnt[c] <= m_cnt[c] +
            (((d == 1) ^ m_inv[c]) ? 32'd1 : 32'hFFFF_FFFF);
      end
      if (we && ad == 3'd0) begin
        m_en  <= wd[1:0];
        m_inv <= wd[5:4];
      end
      if (re) begin
        case (ad)
          3'd0: rv = {26'd0, m_inv, 2'd0, m_en};
          3'd1: rv = {20'd0, hb[1][1], ha[1][1],
                      hb[1][0], ha[1][0], 6'd0, m_err};
          3'd2: rv = m_cnt[0];
          3'd3: rv = m_cnt[1];
          3'd4: rv = m_lat[0];
          3'd5: rv = m_lat[1];
          3'd6: rv = 32'h5145_4E43;
          default: rv = '0;
        endcase
        m_resp <= rv;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (resp !== m_resp) begin
        errs++;
        $display("FAIL model_resp t=%0t got=%h exp=%h",
                 $time, resp, m_resp);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    @(negedge clk);
    cmd = {1'b1, 1'b1, a, d};
    @(negedge clk);
    cmd = '0;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [31:0] d);
    @(negedge clk);
    cmd = {1'b1, 1'b0, a, 32'd0};
    @(posedge clk);
    #1 d = resp;
    @(negedge clk);
    cmd = '0;
  endtask

  task automatic qstep(int c, int dir);
    logic [1:0] p;
    pos[c] = (pos[c] + dir) & 3;
    p = 2'(pos[c]);
    @(negedge clk);
    qa[c] = p[1];
    qb[c] = p[1] ^ p[0];
    cyc(3);
  endtask

  initial begin
    logic [31:0] v;
    pos[0] = 0;
    pos[1] = 0;
    cyc(3);
    chk("reset_resp", resp, 32'd0);
    rst = 1'b0;
    rd(3'd6, v); chk("id", v, 32'h5145_4E43);
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v); chk("reset_reg", v, 32'd0);
    end

    wr(3'd0, 32'h1);
    repeat (4) qstep(0, 1);
    cyc(3);
    rd(3'd2, v); chk("fwd4", v, 32'd4);
    wr(3'd0, 32'h11);
    repeat (4) qstep(0, 1);
    cyc(3);
    rd(3'd2, v); chk("inv4", v, 32'd0);

    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd0, 32'h13);
    qstep(1, 1);
    cyc(3);
    rd(3'd3, v); chk("wrap_up", v, 32'd0);
    qstep(1, -1);
    cyc(3);
    rd(3'd3, v); chk("wrap_dn", v, 32'hFFFF_FFFF);

    @(negedge clk);
    qa[0] = 1'b1; qb[0] = 1'b1; pos[0] = 2;
    cyc(4);
    rd(3'd1, v); chk("err_set", v & 32'h1, 32'h1);
    rd(3'd2, v); chk("err_cnt", v, 32'd0);
    @(negedge clk);
    qa[0] = 1'b0; qb[0] = 1'b0; pos[0] = 0;
    @(negedge clk);
    @(negedge clk);
    cmd = {1'b1, 1'b1, 3'd1, 32'h1};
    @(negedge clk);
    cmd = '0;
    rd(3'd1, v); chk("err_set_wins", v & 32'h1, 32'h1);
    wr(3'd1, 32'h1);
    rd(3'd1, v); chk("err_clr", v & 32'h1, 32'h0);

    wr(3'd0, 32'h1);
    wr(3'd2, 32'd10);
    @(negedge clk);
    qa[0] = 1'b0; qb[0] = 1'b1; qz[0] = 1'b1; pos[0] = 1;
    cyc(4);
    rd(3'd4, v); chk("latch0", v, 32'd10);
    rd(3'd2, v); chk("cnt_idx", v, 32'd11);
    repeat (3) begin
      @(negedge clk); qz[1] = ~qz[1];
      cyc(3);
    end
    rd(3'd5, v); chk("latch1_dis", v, 32'd0);

    qstep(0, 1);
    qstep(0, 1);
    @(negedge clk);
    rst = 1'b1;
    qa[0] = 1'b1; qb[0] = 1'b1; pos[0] = 2;
    cyc(2);
    chk("midrst_resp", resp, 32'd0);
    rst = 1'b0;
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), v);
      chk("midrst_reg", a == 1 ? v & 32'h3 : v, 32'd0);
    end
    wr(3'd0, 32'h1);
    cyc(6);
    rd(3'd2, v); chk("static11", v, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          qa[c] = 1'($urandom);
          qb[c] = 1'($urandom);
        end
        if ($urandom_range(0, 9) == 0) qz[c] = ~qz[c];
      end
      if ($urandom_range(0, 1) == 0) begin
        cmd = {1'b1, 1'($urandom_range(0, 3) == 0),
               3'($urandom), 32'($urandom)};
        if (cmd[35] && cmd[34:32] == 3'd0)
          cmd[31:0] = cmd[31:0] | 32'h3;
      end else begin
        cmd = '0;
      end
    end
    @(negedge clk);
    cmd = '0;
    cyc(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
